// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_pkg
// Purpose  : Shared channel state encoding and constants for the data-memory
//            request controller.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int unsigned c_DEPTH_WORDS = 128;
  localparam logic [31:0] c_RESP_ZERO   = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } chan_state_t;

  function automatic logic [29:0] WORD_IDX(input logic [31:0] addr);
    return 30'(addr >> 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_req_chan.sv
`default_nettype none
// ============================================================================
// Module   : dmem_req_chan
// Purpose  : One core load/store channel: IDLE/ISSUE/RESP FSM, request
//            register and registered one-cycle response.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_req_chan
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic        i_grant,
  input  logic        i_addr_err,
  input  logic [31:0] i_mem_rdata,
  output logic        o_issue,
  output logic        o_write,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_data,
  output logic        o_resp_err
);

  chan_state_t r_state;
  logic        r_ready;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_resp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= c_RESP_ZERO;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid && r_ready) begin
            r_write <= i_req_write;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_ready <= 1'b0;
            r_state <= ST_ISSUE;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // Memory data is sampled on the same edge the access is granted.
          if (i_grant) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= i_addr_err;
            r_resp_data  <= (r_write || i_addr_err) ? c_RESP_ZERO : i_mem_rdata;
          end
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_data  <= c_RESP_ZERO;
          r_resp_err   <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_ready      <= 1'b0;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready  = r_ready;
  assign o_issue      = (r_state == ST_ISSUE);
  assign o_write      = r_write;
  assign o_addr       = r_addr;
  assign o_wdata      = r_wdata;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: rtl/dmem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_req_ctrl
// Purpose  : Dual-core initiator for the dual-port data memory with same-word
//            conflict serialisation, range check and conflict counter.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_req_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = c_DEPTH_WORDS,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ReqValid0,
  input  logic             ReqValid1,
  output logic             ReqReady0,
  output logic             ReqReady1,
  input  logic             ReqWrite0,
  input  logic             ReqWrite1,
  input  logic [31:0]      ReqAddress0,
  input  logic [31:0]      ReqAddress1,
  input  logic [31:0]      ReqWriteData0,
  input  logic [31:0]      ReqWriteData1,
  output logic             RespValid0,
  output logic             RespValid1,
  output logic [31:0]      RespData0,
  output logic [31:0]      RespData1,
  output logic             RespErr0,
  output logic             RespErr1,
  output logic             MemRSTA,
  output logic             MemRSTB,
  output logic             MemWriteEnableA,
  output logic             MemWriteEnableB,
  output logic [31:0]      MemAddressA,
  output logic [31:0]      MemAddressB,
  output logic [31:0]      MemWriteDataA,
  output logic [31:0]      MemWriteDataB,
  input  logic [31:0]      MemReadDataA,
  input  logic [31:0]      MemReadDataB,
  output logic [CNT_W-1:0] ConflictCount
);

  logic             w_issue0, w_issue1;
  logic             w_write0, w_write1;
  logic [31:0]      w_addr0, w_addr1;
  logic             w_err0, w_err1;
  logic             w_conflict;
  logic             w_grant0, w_grant1;
  logic             r_prio;
  logic             r_mem_rst;
  logic [CNT_W-1:0] r_cnt;

  dmem_req_chan u_chan0 (
    .clk          (CLK),
    .rst_n        (RST),
    .i_req_valid  (ReqValid0),
    .o_req_ready  (ReqReady0),
    .i_req_write  (ReqWrite0),
    .i_req_addr   (ReqAddress0),
    .i_req_wdata  (ReqWriteData0),
    .i_grant      (w_grant0),
    .i_addr_err   (w_err0),
    .i_mem_rdata  (MemReadDataA),
    .o_issue      (w_issue0),
    .o_write      (w_write0),
    .o_addr       (w_addr0),
    .o_wdata      (MemWriteDataA),
    .o_resp_valid (RespValid0),
    .o_resp_data  (RespData0),
    .o_resp_err   (RespErr0)
  );

  dmem_req_chan u_chan1 (
    .clk          (CLK),
    .rst_n        (RST),
    .i_req_valid  (ReqValid1),
    .o_req_ready  (ReqReady1),
    .i_req_write  (ReqWrite1),
    .i_req_addr   (ReqAddress1),
    .i_req_wdata  (ReqWriteData1),
    .i_grant      (w_grant1),
    .i_addr_err   (w_err1),
    .i_mem_rdata  (MemReadDataB),
    .o_issue      (w_issue1),
    .o_write      (w_write1),
    .o_addr       (w_addr1),
    .o_wdata      (MemWriteDataB),
    .o_resp_valid (RespValid1),
    .o_resp_data  (RespData1),
    .o_resp_err   (RespErr1)
  );

  assign w_err0 = (WORD_IDX(w_addr0) >= 30'(DEPTH_WORDS));
  assign w_err1 = (WORD_IDX(w_addr1) >= 30'(DEPTH_WORDS));

  // Same-word accesses with any store are serialised; read/read is not.
  assign w_conflict = w_issue0 && w_issue1 &&
                      (WORD_IDX(w_addr0) == WORD_IDX(w_addr1)) &&
                      (w_write0 || w_write1);
  assign w_grant0   = w_issue0 && (!w_conflict || !r_prio);
  assign w_grant1   = w_issue1 && (!w_conflict ||  r_prio);

  assign MemWriteEnableA = w_grant0 && w_write0 && !w_err0;
  assign MemWriteEnableB = w_grant1 && w_write1 && !w_err1;
  assign MemAddressA     = w_addr0;
  assign MemAddressB     = w_addr1;
  assign MemRSTA         = r_mem_rst;
  assign MemRSTB         = r_mem_rst;
  assign ConflictCount   = r_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_mem_rst <= 1'b1;
      r_prio    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_mem_rst <= 1'b0;
      if (w_conflict) begin
        r_prio <= ~r_prio;
        if (r_cnt != {CNT_W{1'b1}}) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_req_ctrl
// Purpose  : Directed self-checking bench for dmem_req_ctrl with a 128-word
//            dual-port memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_req_ctrl;

  logic        CLK;
  logic        RST;
  logic        ReqValid0, ReqValid1;
  logic        ReqReady0, ReqReady1;
  logic        ReqWrite0, ReqWrite1;
  logic [31:0] ReqAddress0, ReqAddress1;
  logic [31:0] ReqWriteData0, ReqWriteData1;
  logic        RespValid0, RespValid1;
  logic [31:0] RespData0, RespData1;
  logic        RespErr0, RespErr1;
  logic        MemRSTA, MemRSTB;
  logic        MemWriteEnableA, MemWriteEnableB;
  logic [31:0] MemAddressA, MemAddressB;
  logic [31:0] MemWriteDataA, MemWriteDataB;
  logic [31:0] MemReadDataA, MemReadDataB;
  logic [15:0] ConflictCount;

  logic [31:0] mem [0:127];
  logic        pre_we;
  logic [6:0]  pre_idx;
  logic [31:0] pre_data;

  int n_assert;
  int n_fail;

  dmem_req_ctrl #(.DEPTH_WORDS(128), .CNT_W(16)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .ReqValid0       (ReqValid0),
    .ReqValid1       (ReqValid1),
    .ReqReady0       (ReqReady0),
    .ReqReady1       (ReqReady1),
    .ReqWrite0       (ReqWrite0),
    .ReqWrite1       (ReqWrite1),
    .ReqAddress0     (ReqAddress0),
    .ReqAddress1     (ReqAddress1),
    .ReqWriteData0   (ReqWriteData0),
    .ReqWriteData1   (ReqWriteData1),
    .RespValid0      (RespValid0),
    .RespValid1      (RespValid1),
    .RespData0       (RespData0),
    .RespData1       (RespData1),
    .RespErr0        (RespErr0),
    .RespErr1        (RespErr1),
    .MemRSTA         (MemRSTA),
    .MemRSTB         (MemRSTB),
    .MemWriteEnableA (MemWriteEnableA),
    .MemWriteEnableB (MemWriteEnableB),
    .MemAddressA     (MemAddressA),
    .MemAddressB     (MemAddressB),
    .MemWriteDataA   (MemWriteDataA),
    .MemWriteDataB   (MemWriteDataB),
    .MemReadDataA    (MemReadDataA),
    .MemReadDataB    (MemReadDataB),
    .ConflictCount   (ConflictCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign MemReadDataA = (MemAddressA[31:9] == 23'h0) ? mem[MemAddressA[8:2]] : 32'h0;
  assign MemReadDataB = (MemAddressB[31:9] == 23'h0) ? mem[MemAddressB[8:2]] : 32'h0;

  always @(posedge CLK) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    if (MemWriteEnableA && !MemRSTA && MemAddressA[31:9] == 23'h0)
      mem[MemAddressA[8:2]] <= MemWriteDataA;
    if (MemWriteEnableB && !MemRSTB && MemAddressB[31:9] == 23'h0)
      mem[MemAddressB[8:2]] <= MemWriteDataB;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    pre_we   = 1'b1;
    pre_idx  = 7'(idx);
    pre_data = data;
    @(negedge CLK);
    pre_we   = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    RST = 1'b0;
    ReqValid0 = 0; ReqValid1 = 0; ReqWrite0 = 0; ReqWrite1 = 0;
    ReqAddress0 = 0; ReqAddress1 = 0; ReqWriteData0 = 0; ReqWriteData1 = 0;
    pre_we = 0; pre_idx = 0; pre_data = 0;

    @(negedge CLK);
    preload(4, 32'h0);
    preload(8, 32'h55);
    preload(16, 32'h0);
    preload(2, 32'h77);
    for (int k = 0; k < 4; k++) preload(32 + k, 32'h100 + k);

    // Reset state
    chk("rst_ready0", {31'h0, ReqReady0}, 32'd0);
    chk("rst_ready1", {31'h0, ReqReady1}, 32'd0);
    chk("rst_rvalid0", {31'h0, RespValid0}, 32'd0);
    chk("rst_memrsta", {31'h0, MemRSTA}, 32'd1);
    chk("rst_memrstb", {31'h0, MemRSTB}, 32'd1);
    chk("rst_wea", {31'h0, MemWriteEnableA}, 32'd0);
    chk("rst_cnt", {16'h0, ConflictCount}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("rel_ready0", {31'h0, ReqReady0}, 32'd1);
    chk("rel_ready1", {31'h0, ReqReady1}, 32'd1);
    chk("rel_memrsta", {31'h0, MemRSTA}, 32'd0);

    // Reset while a store is in ISSUE
    ReqValid0 = 1; ReqWrite0 = 1; ReqAddress0 = 32'h10; ReqWriteData0 = 32'hDEAD;
    @(negedge CLK);
    ReqValid0 = 0;
    chk("mid_accept_ready0", {31'h0, ReqReady0}, 32'd0);
    chk("mid_issue_wea", {31'h0, MemWriteEnableA}, 32'd1);
    RST = 1'b0;
    #1;
    chk("mid_rst_wea", {31'h0, MemWriteEnableA}, 32'd0);
    chk("mid_rst_memrsta", {31'h0, MemRSTA}, 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_rst_rvalid0", {31'h0, RespValid0}, 32'd0);
    chk("mid_rst_word4", mem[4], 32'h0);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rel_ready0", {31'h0, ReqReady0}, 32'd1);
    chk("mid_rel_rvalid0", {31'h0, RespValid0}, 32'd0);
    chk("mid_rel_cnt", {16'h0, ConflictCount}, 32'd0);

    // Independent store (core0) and load (core1)
    ReqValid0 = 1; ReqWrite0 = 1; ReqAddress0 = 32'h10; ReqWriteData0 = 32'h11;
    ReqValid1 = 1; ReqWrite1 = 0; ReqAddress1 = 32'h20;
    @(negedge CLK);
    ReqValid0 = 0; ReqValid1 = 0;
    chk("ind_ready0", {31'h0, ReqReady0}, 32'd0);
    chk("ind_rvalid0_early", {31'h0, RespValid0}, 32'd0);
    @(negedge CLK);
    chk("ind_rvalid0", {31'h0, RespValid0}, 32'd1);
    chk("ind_rvalid1", {31'h0, RespValid1}, 32'd1);
    chk("ind_rdata1", RespData1, 32'h55);
    chk("ind_rdata0", RespData0, 32'h0);
    chk("ind_rerr0", {31'h0, RespErr0}, 32'd0);
    chk("ind_word4", mem[4], 32'h11);
    @(negedge CLK);
    chk("ind_pulse0", {31'h0, RespValid0}, 32'd0);
    chk("ind_ready_again", {31'h0, ReqReady0}, 32'd1);

    // Same-word store conflict, priority starts at core0
    ReqValid0 = 1; ReqWrite0 = 1; ReqAddress0 = 32'h40; ReqWriteData0 = 32'hA;
    ReqValid1 = 1; ReqWrite1 = 1; ReqAddress1 = 32'h40; ReqWriteData1 = 32'hB;
    @(negedge CLK);
    ReqValid0 = 0; ReqValid1 = 0;
    chk("c1_wea", {31'h0, MemWriteEnableA}, 32'd1);
    chk("c1_web_blocked", {31'h0, MemWriteEnableB}, 32'd0);
    @(negedge CLK);
    chk("c1_rvalid0", {31'h0, RespValid0}, 32'd1);
    chk("c1_rvalid1_held", {31'h0, RespValid1}, 32'd0);
    chk("c1_word16_first", mem[16], 32'hA);
    chk("c1_cnt", {16'h0, ConflictCount}, 32'd1);
    chk("c1_web", {31'h0, MemWriteEnableB}, 32'd1);
    @(negedge CLK);
    chk("c1_rvalid1", {31'h0, RespValid1}, 32'd1);
    chk("c1_word16_final", mem[16], 32'hB);
    chk("c1_cnt_hold", {16'h0, ConflictCount}, 32'd1);
    @(negedge CLK);

    // Repeat: priority now on core1
    ReqValid0 = 1; ReqValid1 = 1;
    @(negedge CLK);
    ReqValid0 = 0; ReqValid1 = 0;
    chk("c2_web", {31'h0, MemWriteEnableB}, 32'd1);
    chk("c2_wea_blocked", {31'h0, MemWriteEnableA}, 32'd0);
    @(negedge CLK);
    chk("c2_rvalid1", {31'h0, RespValid1}, 32'd1);
    chk("c2_rvalid0_held", {31'h0, RespValid0}, 32'd0);
    chk("c2_word16_first", mem[16], 32'hB);
    chk("c2_cnt", {16'h0, ConflictCount}, 32'd2);
    @(negedge CLK);
    chk("c2_rvalid0", {31'h0, RespValid0}, 32'd1);
    chk("c2_word16_final", mem[16], 32'hA);
    @(negedge CLK);

    // Read/read of the same word is not a conflict
    ReqValid0 = 1; ReqWrite0 = 0; ReqAddress0 = 32'h8;
    ReqValid1 = 1; ReqWrite1 = 0; ReqAddress1 = 32'h8;
    @(negedge CLK);
    ReqValid0 = 0; ReqValid1 = 0;
    @(negedge CLK);
    chk("rr_rvalid0", {31'h0, RespValid0}, 32'd1);
    chk("rr_rvalid1", {31'h0, RespValid1}, 32'd1);
    chk("rr_rdata0", RespData0, 32'h77);
    chk("rr_rdata1", RespData1, 32'h77);
    chk("rr_cnt", {16'h0, ConflictCount}, 32'd2);
    @(negedge CLK);

    // Out-of-range store on core1 (word index 128)
    ReqValid1 = 1; ReqWrite1 = 1; ReqAddress1 = 32'h200; ReqWriteData1 = 32'h99;
    @(negedge CLK);
    ReqValid1 = 0;
    chk("oor_web", {31'h0, MemWriteEnableB}, 32'd0);
    @(negedge CLK);
    chk("oor_rvalid1", {31'h0, RespValid1}, 32'd1);
    chk("oor_rerr1", {31'h0, RespErr1}, 32'd1);
    chk("oor_rdata1", RespData1, 32'h0);
    @(negedge CLK);
    chk("oor_rerr1_clear", {31'h0, RespErr1}, 32'd0);

    // Back-to-back loads with ReqValid0 held high
    ReqValid0 = 1; ReqWrite0 = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b%0d_ready", k), {31'h0, ReqReady0}, 32'd1);
      ReqAddress0 = 32'h80 + 32'(4 * k);
      @(negedge CLK);
      chk($sformatf("b2b%0d_busy", k), {31'h0, ReqReady0}, 32'd0);
      chk($sformatf("b2b%0d_nopulse", k), {31'h0, RespValid0}, 32'd0);
      @(negedge CLK);
      chk($sformatf("b2b%0d_rvalid", k), {31'h0, RespValid0}, 32'd1);
      chk($sformatf("b2b%0d_rdata", k), RespData0, 32'h100 + 32'(k));
      @(negedge CLK);
      chk($sformatf("b2b%0d_pulse_end", k), {31'h0, RespValid0}, 32'd0);
    end
    ReqValid0 = 0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_req_ctrl.md
Name: dmem_req_ctrl

Overview:
- Initiator side of the dual-port data memory: each core gets one load/store channel, and the block drives one memory port per core.
- Core 0 maps to port A, core 1 to port B.
- Each channel holds one outstanding request at a time.
- The block serialises same-word conflicts with round-robin priority, suppresses out-of-range accesses, and returns a registered one-cycle response.
- Sits between the per-core MEM pipeline stage and the data memory.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words in the data memory; word index = address[31:2].
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- ReqValid0/1  in  1  core request valid.
- ReqReady0/1  out  1  channel can accept a request.
- ReqWrite0/1  in  1  1 = store, 0 = load.
- ReqAddress0/1  in  32  byte address; bits [1:0] ignored.
- ReqWriteData0/1  in  32  store data.
- RespValid0/1  out  1  one-cycle response pulse.
- RespData0/1  out  32  load data; 0 for stores and errors.
- RespErr0/1  out  1  address out of range; valid with RespValid.
- MemRSTA/MemRSTB  out  1  memory port hold; 1 blocks memory writes.
- MemWriteEnableA/B  out  1  memory write enable.
- MemAddressA/B  out  32  memory byte address.
- MemWriteDataA/B  out  32  memory write data.
- MemReadDataA/B  in  32  combinational memory read data.
- ConflictCount  out  CNT_W  saturating count of conflict cycles.

Behaviour:
- Reset (RST=0, async):
  - Both channels go to IDLE; in-flight requests are discarded with no response.
  - ReqReady=0, RespValid=0, RespData=0, RespErr=0.
  - MemWriteEnable=0, MemRST=1, priority bit=0, ConflictCount=0.
  - MemRST and ReqReady become 0 and 1 respectively on the first CLK edge after RST rises.
- Per-channel FSM IDLE -> ISSUE -> RESP -> IDLE:
  - IDLE: ReqReady=1. On ReqValid&ReqReady, latch write, address and data into the request register and move to ISSUE.
  - ISSUE: ReqReady=0. If granted, the access happens at this edge and the channel moves to RESP. If not granted, it stays in ISSUE and holds the request.
  - RESP: RespValid=1 for exactly one cycle; there is no backpressure. Next state is IDLE, so ReqReady=1 again on the following cycle.
- Latency: acceptance edge E -> memory access at edge E+1 -> RespValid high during the cycle after E+1. Best case is one request per channel every 3 cycles.
- Memory drive:
  - MemAddress and MemWriteData always reflect the channel's request register.
  - MemWriteEnable = in ISSUE & granted & write & in range. It is never asserted otherwise.
- Load: RespData takes MemReadData at the grant edge.
- Store: RespData=0; the write is committed at the grant edge.
- Range check: word index >= DEPTH_WORDS gives no write, RespData=0 and RespErr=1. The access is still granted and still counts toward conflicts.
- Conflict:
  - Condition: both channels in ISSUE, equal address[31:2], and at least one is a write.
  - Only the channel selected by the priority bit is granted (0 -> core0, 1 -> core1).
  - The priority bit toggles on every conflict cycle.
  - ConflictCount increments and saturates at all-ones.
  - Same-word read/read and different-word accesses are both granted in the same cycle.
- Read of a word the other port writes in the same edge, at a different word: not possible. Same word is always serialised, so a load never sees a half-committed store.
- Address bits [1:0] are passed to the memory unchanged and are ignored for matching.

Decomposition:
- Shared package mem_pkg:
  - Channel state encoding (IDLE, ISSUE, RESP).
  - WORD_IDX(addr) helper slice [31:2].
  - Default DEPTH_WORDS, and the response constant RESP_ZERO=32'h0.
- One sub-module, dmem_req_chan: per-channel FSM, request register and response register, instantiated twice.
- The top level holds the conflict/priority logic, range check and counter.

Test Plan:
- Reset mid-operation: core0 store accepted, RST pulled low during ISSUE -> no RespValid0, MemWriteEnableA=0, ConflictCount=0, ReqReady0=1 one edge after release.
- Independent: core0 store 0x11 to 0x10 and core1 load 0x20 (preloaded 0x55), same cycle -> both RespValid 2 cycles after acceptance, RespData1=0x55, word 4=0x11.
- Conflict: both store to 0x40 (0xA, 0xB) same cycle -> core0 written first, core1 one cycle later, final word 16=0xB, ConflictCount=1. Repeat -> core1 first, final 0xA, count=2.
- Read/read same word 0x8 (holds 0x77) -> both granted same cycle, RespData0=RespData1=0x77, count unchanged.
- Out of range: core1 store to 0x200 (index 128) -> MemWriteEnableB never 1, RespErr1=1, RespData1=0.
- Back-to-back: core0 holds ReqValid high for 4 loads -> accepted every 3 cycles, RespValid0 one-cycle pulses, data in order.
